// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: LCG-packed IN_W-bit stimulus vectors on valid/ready; LCG_STIM_STALL_CNT_EN adds stall_cnt
module lcg_stim_gen #(
  parameter int          IN_W    = 137,
  parameter int          CNT_W   = 32,
  parameter logic [31:0] LCG_MUL = 32'h41C64E6D,
  parameter logic [31:0] LCG_INC = 32'h00003039
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_vec,
  output logic [IN_W-1:0]  vec_data,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [CNT_W-1:0] vec_idx,
  output logic [31:0]      rng_state,
  output logic             busy,
  output logic             done
`ifdef LCG_STIM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  localparam int NWORDS = (IN_W + 31) / 32;
  localparam int LAST_W = IN_W - 32 * (NWORDS - 1);
  localparam int W_W    = $clog2(NWORDS + 1);
  typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;
  state_t           r_state, w_next_state;
  logic [31:0]      r_rng, w_rng_next;
  logic [CNT_W-1:0] r_num, r_idx;
  logic [W_W-1:0]   r_w;
  logic [IN_W-1:0]  r_data;
  logic             w_start, w_last_word, w_accept, w_last_vec;
  assign w_rng_next  = r_rng * LCG_MUL + LCG_INC;
  assign w_start     = r_state == IDLE && start;
  assign w_last_word = r_w == W_W'(NWORDS - 1);
  assign w_accept    = r_state == PRESENT && vec_ready;
  assign w_last_vec  = r_idx == r_num - CNT_W'(1);
  assign vec_data    = r_data;
  assign vec_valid   = r_state == PRESENT;
  assign vec_idx     = r_idx;
  assign rng_state   = r_rng;
  assign busy        = r_state == FILL || r_state == PRESENT;
  assign done        = r_state == DONE;
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next_state;
  end
  // next-state: zero-length runs go straight to DONE, last accepted vector ends the run
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = (num_vec == '0) ? DONE : FILL;
      FILL:    if (w_last_word) w_next_state = PRESENT;
      PRESENT: if (vec_ready) w_next_state = w_last_vec ? DONE : FILL;
      default: w_next_state = IDLE;
    endcase
  end
  // datapath: latch run config, one LCG step per FILL cycle into word r_w, advance index on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rng  <= '0;
      r_num  <= '0;
      r_idx  <= '0;
      r_w    <= '0;
      r_data <= '0;
    end else if (w_start) begin
      r_rng <= seed;
      r_num <= num_vec;
      r_idx <= '0;
      r_w   <= '0;
    end else if (r_state == FILL) begin
      r_rng <= w_rng_next;
      r_w   <= r_w + W_W'(1);
      for (int k = 0; k < NWORDS - 1; k++)
        if (r_w == W_W'(k)) r_data[32*k +: 32] <= w_rng_next;
      if (w_last_word) r_data[IN_W-1:32*(NWORDS-1)] <= w_rng_next[LAST_W-1:0];
    end else if (w_accept) begin
      r_w <= '0;
      if (!w_last_vec) r_idx <= r_idx + CNT_W'(1);
    end
  end
`ifdef LCG_STIM_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall;
  assign stall_cnt = r_stall;
  // saturating count of presented-but-not-accepted cycles, cleared when a run starts
  always_ff @(posedge clk) begin
    if (rst || w_start) r_stall <= '0;
    else if (r_state == PRESENT && !vec_ready && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: directed checks of lcg_stim_gen packing, latency, handshake, reset and start filtering
module tb_lcg_stim_gen;
  localparam int IN_W   = 137;
  localparam int NWORDS = (IN_W + 31) / 32;
  localparam int CNT_W  = 32;
  logic             clk = 1'b0;
  logic             rst, start, vec_ready;
  logic [31:0]      seed;
  logic [CNT_W-1:0] num_vec;
  logic [IN_W-1:0]  vec_data;
  logic             vec_valid, busy, done;
  logic [CNT_W-1:0] vec_idx;
  logic [31:0]      rng_state;
`ifdef LCG_STIM_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif
  int n_vec = 0;
  int n_bad = 0;
  lcg_stim_gen dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vec(num_vec),
    .vec_data(vec_data), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_idx(vec_idx), .rng_state(rng_state), .busy(busy), .done(done)
`ifdef LCG_STIM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h00003039;
  endfunction
  task automatic gen(inout logic [31:0] st, output logic [159:0] v);
    v = '0;
    for (int k = 0; k < NWORDS; k++) begin
      st = lcg(st);
      v[32*k +: 32] = st;
    end
    v = v & ((160'd1 << IN_W) - 160'd1);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [31:0] s, input logic [CNT_W-1:0] n);
    seed = s;
    num_vec = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!vec_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!vec_valid) chk("valid_timeout", 160'(vec_valid), 160'd1);
  endtask
  task automatic chk_vec(input string tag, inout logic [31:0] st);
    logic [159:0] v;
    gen(st, v);
    chk(tag, 160'(vec_data), v);
    chk({tag, "_rng"}, 160'(rng_state), 160'(st));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0]  st, rs;
    logic [159:0] v, v0;
    int           cyc, cnt;
    rst = 1'b1; start = 1'b1; seed = 32'hDEADBEEF; num_vec = 5; vec_ready = 1'b0;
    tick(); tick();
    chk("rst_data", 160'(vec_data), 160'd0);
    chk("rst_valid", 160'(vec_valid), 160'd0);
    chk("rst_idx", 160'(vec_idx), 160'd0);
    chk("rst_rng", 160'(rng_state), 160'd0);
    chk("rst_busy", 160'(busy), 160'd0);
    chk("rst_done", 160'(done), 160'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("idle_busy", 160'(busy), 160'd0);
    // seed 0, one vector, consumer always ready
    vec_ready = 1'b1;
    launch(32'd0, 1);
    wait_valid(cyc);
    chk("lat_first", 160'(cyc + 1), 160'd6);
    chk("w0", 160'(vec_data[31:0]), 160'h00003039);
    chk("w1", 160'(vec_data[63:32]), 160'hD3DC167E);
    v0 = 160'(vec_data);
    st = 32'd0;
    chk_vec("v_seed0", st);
    tick();
    chk("done1", 160'(done), 160'd1);
    chk("valid_drop", 160'(vec_valid), 160'd0);
    seed = 32'd0; num_vec = 1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_once", 160'(done), 160'd0);
    tick();
    chk("done_start_ign", 160'(busy), 160'd0);
    // zero-length run
    launch(32'h1234, 0);
    chk("nv0_done", 160'(done), 160'd1);
    chk("nv0_valid", 160'(vec_valid), 160'd0);
    chk("nv0_hold", 160'(vec_data), v0);
    chk("nv0_seed", 160'(rng_state), 160'h1234);
    tick();
    chk("nv0_done_end", 160'(done), 160'd0);
    chk("nv0_busy", 160'(busy), 160'd0);
    // long run, ready held high
    st = 32'd3965891272;
    launch(st, 100);
    for (int i = 0; i < 100; i++) begin
      wait_valid(cyc);
      chk("period", 160'(cyc + 1), 160'd6);
      chk("idx", 160'(vec_idx), 160'(i));
      chk_vec("v100", st);
      tick();
    end
    chk("done100", 160'(done), 160'd1);
    chk("idx_last", 160'(vec_idx), 160'd99);
    tick();
    chk("done100_end", 160'(done), 160'd0);
    // backpressure
    vec_ready = 1'b0;
    st = 32'hCAFEF00D;
    launch(st, 2);
    wait_valid(cyc);
    chk_vec("bp_v0", st);
    v = 160'(vec_data);
    rs = rng_state;
    for (int i = 0; i < 7; i++) tick();
    chk("bp_valid", 160'(vec_valid), 160'd1);
    chk("bp_data", 160'(vec_data), v);
    chk("bp_rng", 160'(rng_state), 160'(rs));
    chk("bp_idx", 160'(vec_idx), 160'd0);
`ifdef LCG_STIM_STALL_CNT_EN
    chk("bp_stall", 160'(stall_cnt), 160'd7);
`endif
    vec_ready = 1'b1;
    tick();
    chk("bp_drop", 160'(vec_valid), 160'd0);
    wait_valid(cyc);
    chk_vec("bp_v1", st);
    chk("bp_idx1", 160'(vec_idx), 160'd1);
    tick();
    chk("bp_done", 160'(done), 160'd1);
    tick();
`ifdef LCG_STIM_STALL_CNT_EN
    chk("bp_stall_hold", 160'(stall_cnt), 160'd7);
`endif
    // start while busy is ignored
    st = 32'h00000007;
    launch(st, 3);
    seed = 32'd0; num_vec = 1; start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(cyc);
      chk_vec("bz", st);
      chk("bz_idx", 160'(vec_idx), 160'(i));
      tick();
    end
    chk("bz_done", 160'(done), 160'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vec_valid || busy) cnt++;
    end
    chk("bz_extra", 160'(cnt), 160'd0);
    // reset during FILL of vector 2
    st = 32'h00000009;
    launch(st, 5);
    wait_valid(cyc);
    tick();
    wait_valid(cyc);
    tick();
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_data", 160'(vec_data), 160'd0);
    chk("mrst_valid", 160'(vec_valid), 160'd0);
    chk("mrst_idx", 160'(vec_idx), 160'd0);
    chk("mrst_rng", 160'(rng_state), 160'd0);
    chk("mrst_busy", 160'(busy), 160'd0);
    chk("mrst_done", 160'(done), 160'd0);
`ifdef LCG_STIM_STALL_CNT_EN
    chk("mrst_stall", 160'(stall_cnt), 160'd0);
`endif
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) cnt++;
    end
    chk("mrst_no_done", 160'(cnt), 160'd0);
    launch(32'h00000009, 1);
    wait_valid(cyc);
    st = 32'h00000009;
    chk_vec("mrst_repro", st);
    tick();
    chk("mrst_repro_done", 160'(done), 160'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
